pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Centralised pipeline control for the in-order core. Replaces hand-wired per-stage enables with a
//  parametrised N-stage controller. Owns per-stage valid bits and register enables; detects load-use
//  hazards; handles taken-branch squash, external flush and multi-cycle data-memory waits with timeout.
//  Sits beside fetch/decode/alu/mem/writeB stages inside core.
// PARAMETERS
//  NSTAGES      5   pipeline depth; stage 0 = fetch, stage NSTAGES-1 = writeback
//  EX_STAGE     2   stage producing ALU result / load address
//  MEM_STAGE    3   stage issuing dmem access and resolving branches
//  REG_W        5   register-index width
//  MEM_TIMEOUT  15  max dmem wait cycles before abort (>=1)
//  CNT_W        16  perf-counter width
// PORTS
//  clk            in   1        clock, rising edge
//  reset          in   1        async, active-low
//  flush          in   1        external flush, synchronous request
//  if_valid       in   1        fetch presents a valid instruction this cycle
//  id_rs, id_rt   in   REG_W    source regs of the instruction in decode
//  id_use_rs/rt   in   1        decode instruction reads rs / rt
//  ex_mem_read    in   1        EX instruction is a load
//  ex_rd          in   REG_W    EX destination reg
//  br_taken       in   1        branch taken at MEM_STAGE (qualified internally by valid[MEM_STAGE])
//  dmem_req       in   1        MEM_STAGE instruction accesses memory
//  dmem_ready     in   1        memory completes access this cycle
//  en_stage       out  NSTAGES  pipeline-register enable per stage; bit 0 = PC write enable
//  valid          out  NSTAGES  stage-holds-real-instruction flags
//  mem_abort      out  1        one-cycle pulse: MEM_STAGE access aborted by timeout (suppress WB)
//  timeout_err    out  1        sticky, set on any abort, cleared only by reset
//  stall_cnt      out  CNT_W    saturating count of cycles with en_stage[0]==0
//  flush_cnt      out  CNT_W    saturating count of squash events (branch or flush)
// BEHAVIOUR
//  Reset: valid=0, en_stage='1, mem_abort=0, timeout_err=0, counters=0, wait counter=0.
//  Per cycle, hazards are evaluated combinationally and state updates on the rising edge. Priority:
//   1 memwait = valid[MEM_STAGE] & dmem_req & ~dmem_ready & ~timeout.
//     en_stage[0..MEM_STAGE]=0 (hold). Stages above MEM_STAGE advance; valid[MEM_STAGE+1] <= 0 (bubble).
//     wait_cnt increments. When wait_cnt reaches MEM_TIMEOUT, the next cycle treats the access as ready:
//     mem_abort=1 for that cycle, valid[MEM_STAGE+1] <= 0, timeout_err <= 1, wait_cnt <= 0.
//     wait_cnt also clears on dmem_ready.
//   2 flush (not memwait): all en_stage=1; valid[0..NSTAGES-2] <= 0; valid[NSTAGES-1] <= valid[NSTAGES-2]
//     (retire proceeds); flush_cnt++. A flush during memwait is held pending and applied on the first
//     non-wait cycle.
//   3 squash = br_taken & valid[MEM_STAGE]: all en_stage=1; valid[1..MEM_STAGE] <= 0 (younger squashed);
//     older stages shift normally; flush_cnt++. Same-cycle load-use is discarded.
//   4 loaduse = valid[EX_STAGE] & ex_mem_read & ex_rd!=0 & valid[EX_STAGE-1] &
//     ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
//     en_stage[0..EX_STAGE-1]=0; valid[EX_STAGE] <= 0 (bubble); younger stages advance. Exactly one stall cycle.
//   5 normal: en_stage='1; valid[0] <= if_valid; valid[i] <= valid[i-1].
//  Register 0 never causes a hazard. Counters saturate at all-ones and do not wrap.
//  Reset asserted mid-stall or mid-wait: everything returns to reset values immediately; pending flush is dropped.
//  Outputs en_stage and mem_abort are combinational from state and inputs; valid and counters are registered.
// STRUCTURE
//  core_pkg: stage-index localparams (STG_IF..STG_WB), hazard_e enum {HZ_NONE,HZ_LOADUSE,HZ_SQUASH,
//   HZ_FLUSH,HZ_MEMWAIT}, saturating-increment function.
//  Sub-module pipe_hazard_detect (combinational: load-use compare plus priority encode to hazard_e).
//  Top holds the valid shift register, wait counter, pending-flush flag and perf counters.
// TESTING
//  T1 reset low mid-run -> valid=0, en_stage=5'b11111, counters=0, timeout_err=0 within same cycle.
//  T2 lw r3 in EX, decode add uses rs=3 -> one cycle en_stage=5'b11100, valid[2]=0 next; rd=0 -> no stall.
//  T3 br_taken with valid[3]=1 -> valid[3:1]<=0, flush_cnt=1; same-cycle load-use ignored.
//  T4 dmem_req, ready after 3 cycles -> en_stage[3:0]=0 for 3 cycles, 3 WB bubbles, stall_cnt=3.
//  T5 dmem_ready never arrives (MEM_TIMEOUT=15) -> mem_abort pulses at cycle 16, timeout_err stays 1.
//  T6 flush during memwait -> deferred until ready, then valid[3:0]<=0; CNT_W=4 with 20 stalls -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit_pkg
//   Shared definitions for the pipeline controller: stage indices of the
//   in-order core, default geometry, the hazard classification enum and a
//   saturating increment used by the performance counters.
// ---------------------------------------------------------------------------
package pipe_ctrl_unit_pkg;

  // Stage indices of the reference five-stage core.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // Default geometry.
  localparam int NSTAGES_DEF     = 5;
  localparam int REG_W_DEF       = 5;
  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF       = 16;

  // Hazard classes, listed from "nothing" up to the highest priority.
  typedef enum logic [2:0] {
    HZ_NONE    = 3'd0,
    HZ_LOADUSE = 3'd1,
    HZ_SQUASH  = 3'd2,
    HZ_FLUSH   = 3'd3,
    HZ_MEMWAIT = 3'd4
  } hazard_e;

  // Increment value, but stick at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? value : (value + 32'd1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit_if
//   Bundle between the core datapath (master) and the pipeline controller
//   (slave).
//   core -> ctrl : flush, if_valid, id_rs/id_rt, id_use_rs/id_use_rt,
//                  ex_mem_read, ex_rd, br_taken, dmem_req, dmem_ready
//   ctrl -> core : en_stage, valid, mem_abort, timeout_err, stall_cnt,
//                  flush_cnt
// ---------------------------------------------------------------------------
interface pipe_ctrl_unit_if
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NSTAGES = NSTAGES_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
);

  logic               flush;
  logic               if_valid;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic               id_use_rs;
  logic               id_use_rt;
  logic               ex_mem_read;
  logic [REG_W-1:0]   ex_rd;
  logic               br_taken;
  logic               dmem_req;
  logic               dmem_ready;
  logic [NSTAGES-1:0] en_stage;
  logic [NSTAGES-1:0] valid;
  logic               mem_abort;
  logic               timeout_err;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  modport master (
    output flush, if_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_mem_read, ex_rd, br_taken, dmem_req, dmem_ready,
    input  en_stage, valid, mem_abort, timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  flush, if_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           ex_mem_read, ex_rd, br_taken, dmem_req, dmem_ready,
    output en_stage, valid, mem_abort, timeout_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_unit_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipe_hazard_detect
//   Purely combinational. Compares the decode sources against a load in EX
//   and priority-encodes the cycle's hazard:
//   memwait > flush > squash > load-use > none.
//   Also flags the cycle in which a timed-out memory access is abandoned.
//   Inputs : valid, flush_req (external or pending), br_taken, decode/EX
//            register info, dmem_req/dmem_ready, timeout (wait limit hit)
//   Outputs: hazard (hazard_e), mem_abort
// ---------------------------------------------------------------------------
module pipe_hazard_detect
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NSTAGES   = NSTAGES_DEF,
  parameter int EX_STAGE  = STG_EX,
  parameter int MEM_STAGE = STG_MEM,
  parameter int REG_W     = REG_W_DEF
) (
  input  logic [NSTAGES-1:0] valid,
  input  logic               flush_req,
  input  logic               br_taken,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               ex_mem_read,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               dmem_req,
  input  logic               dmem_ready,
  input  logic               timeout,
  output hazard_e            hazard,
  output logic               mem_abort
);

  logic loaduse_s;
  logic access_open_s;
  logic memwait_s;
  logic squash_s;

  // Hazard conditions; register 0 is hardwired so it never creates a dependency.
  always_comb begin
    loaduse_s = valid[EX_STAGE] & ex_mem_read & (ex_rd != {REG_W{1'b0}}) & valid[EX_STAGE-1] &
                ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    access_open_s = valid[MEM_STAGE] & dmem_req & ~dmem_ready;
    // Once the wait limit is reached the access is treated as done (aborted).
    memwait_s = access_open_s & ~timeout;
    mem_abort = access_open_s & timeout;
    squash_s  = br_taken & valid[MEM_STAGE];
  end

  // Priority encode the cycle's hazard.
  always_comb begin
    hazard = HZ_NONE;
    if (memwait_s) begin
      hazard = HZ_MEMWAIT;
    end else if (flush_req) begin
      hazard = HZ_FLUSH;
    end else if (squash_s) begin
      hazard = HZ_SQUASH;
    end else if (loaduse_s) begin
      hazard = HZ_LOADUSE;
    end else begin
      hazard = HZ_NONE;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
//   Central pipeline control for the in-order core. Owns the per-stage valid
//   bits, drives the per-stage register enables, stalls on load-use and on
//   slow data memory (with timeout abort), squashes on taken branches and on
//   external flush, and keeps saturating stall/squash counters.
//   Ports: clk, reset (async, active low), bus (pipe_ctrl_unit_if.slave).
//   en_stage and mem_abort are combinational; valid, timeout_err and the
//   counters are registered.
// ---------------------------------------------------------------------------
module pipe_ctrl_unit
  import pipe_ctrl_unit_pkg::*;
#(
  parameter int NSTAGES     = NSTAGES_DEF,
  parameter int EX_STAGE    = STG_EX,
  parameter int MEM_STAGE   = STG_MEM,
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic            clk,
  input logic            reset,
  pipe_ctrl_unit_if.slave bus
);

  localparam int WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  // Stage that receives a bubble while MEM is held or aborted.
  localparam int ABORT_STG = MEM_STAGE + 1;

  logic [NSTAGES-1:0] valid_r;
  logic [NSTAGES-1:0] valid_nxt_s;
  logic [NSTAGES-1:0] en_stage_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               flush_pend_r;
  logic               timeout_err_r;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic [CNT_W-1:0]   flush_cnt_r;
  logic               timeout_s;
  logic               flush_req_s;
  logic               mem_abort_s;
  hazard_e            hz_s;

  assign timeout_s   = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT));
  // A flush that arrived while memory was busy is still owed.
  assign flush_req_s = bus.flush | flush_pend_r;

  pipe_hazard_detect #(
    .NSTAGES   (NSTAGES),
    .EX_STAGE  (EX_STAGE),
    .MEM_STAGE (MEM_STAGE),
    .REG_W     (REG_W)
  ) u_hazard (
    .valid       (valid_r),
    .flush_req   (flush_req_s),
    .br_taken    (bus.br_taken),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_use_rs   (bus.id_use_rs),
    .id_use_rt   (bus.id_use_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .dmem_req    (bus.dmem_req),
    .dmem_ready  (bus.dmem_ready),
    .timeout     (timeout_s),
    .hazard      (hz_s),
    .mem_abort   (mem_abort_s)
  );

  // Stage enables: memwait holds 0..MEM, load-use holds 0..EX-1.
  always_comb begin
    en_stage_s = '1;
    for (int i = 0; i < NSTAGES; i++) begin
      case (hz_s)
        HZ_MEMWAIT: en_stage_s[i] = (i > MEM_STAGE);
        HZ_LOADUSE: en_stage_s[i] = (i >= EX_STAGE);
        default:    en_stage_s[i] = 1'b1;
      endcase
    end
  end

  // Next valid bits: held stages keep their flag, the first advancing stage
  // behind a hold takes a bubble, everything else shifts.
  always_comb begin
    valid_nxt_s = valid_r;
    case (hz_s)
      HZ_MEMWAIT: begin
        for (int i = 1; i < NSTAGES; i++) begin
          valid_nxt_s[i] = (i > ABORT_STG) ? valid_r[i-1] :
                           ((i == ABORT_STG) ? 1'b0 : valid_r[i]);
        end
      end
      HZ_FLUSH: begin
        // The instruction already past the last squashable stage still retires.
        valid_nxt_s            = '0;
        valid_nxt_s[NSTAGES-1] = valid_r[NSTAGES-2];
      end
      HZ_SQUASH: begin
        valid_nxt_s[0] = bus.if_valid;
        for (int i = 1; i < NSTAGES; i++) begin
          valid_nxt_s[i] = (i <= MEM_STAGE) ? 1'b0 : valid_r[i-1];
        end
      end
      HZ_LOADUSE: begin
        for (int i = 1; i < NSTAGES; i++) begin
          valid_nxt_s[i] = (i > EX_STAGE) ? valid_r[i-1] :
                           ((i == EX_STAGE) ? 1'b0 : valid_r[i]);
        end
      end
      default: begin
        valid_nxt_s[0] = bus.if_valid;
        for (int i = 1; i < NSTAGES; i++) begin
          valid_nxt_s[i] = valid_r[i-1];
        end
      end
    endcase
    // An aborted access must not write back.
    valid_nxt_s[ABORT_STG] = mem_abort_s ? 1'b0 : valid_nxt_s[ABORT_STG];
  end

  // Valid shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
    end else begin
      valid_r <= valid_nxt_s;
    end
  end

  // Memory wait counter and deferred flush; both only live across memwait cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r   <= '0;
      flush_pend_r <= 1'b0;
    end else begin
      wait_cnt_r   <= (hz_s == HZ_MEMWAIT) ? (wait_cnt_r + 1'b1) : '0;
      flush_pend_r <= (hz_s == HZ_MEMWAIT) ? flush_req_s : 1'b0;
    end
  end

  // Sticky timeout error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= timeout_err_r | mem_abort_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      stall_cnt_r <= en_stage_s[0] ? stall_cnt_r :
                     CNT_W'(sat_inc(32'(stall_cnt_r), CNT_W));
      flush_cnt_r <= ((hz_s == HZ_FLUSH) || (hz_s == HZ_SQUASH)) ?
                     CNT_W'(sat_inc(32'(flush_cnt_r), CNT_W)) : flush_cnt_r;
    end
  end

  assign bus.en_stage    = en_stage_s;
  assign bus.valid       = valid_r;
  assign bus.mem_abort   = mem_abort_s;
  assign bus.timeout_err = timeout_err_r;
  assign bus.stall_cnt   = stall_cnt_r;
  assign bus.flush_cnt   = flush_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//   Directed bench for pipe_ctrl_unit. A default instance runs the load-use,
//   branch, memory-wait, deferred-flush, timeout and mid-run reset sequences;
//   a second instance with 4-bit counters sits in a permanent memory wait to
//   show counter saturation. Inputs change on the falling edge; outputs are
//   sampled on or just after the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pipe_ctrl_unit_if #(.NSTAGES(5), .REG_W(5), .CNT_W(16)) bus ();
  pipe_ctrl_unit_if #(.NSTAGES(5), .REG_W(5), .CNT_W(4))  sif ();

  pipe_ctrl_unit #(.NSTAGES(5), .EX_STAGE(2), .MEM_STAGE(3), .REG_W(5),
                   .MEM_TIMEOUT(15), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pipe_ctrl_unit #(.NSTAGES(5), .EX_STAGE(2), .MEM_STAGE(3), .REG_W(5),
                   .MEM_TIMEOUT(15), .CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.flush       = 1'b0;
    bus.if_valid    = 1'b0;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.br_taken    = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clear_inputs();
    sif.flush       = 1'b0;
    sif.if_valid    = 1'b0;
    sif.id_rs       = 5'd0;
    sif.id_rt       = 5'd0;
    sif.id_use_rs   = 1'b0;
    sif.id_use_rt   = 1'b0;
    sif.ex_mem_read = 1'b0;
    sif.ex_rd       = 5'd0;
    sif.br_taken    = 1'b0;
    sif.dmem_req    = 1'b0;
    sif.dmem_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.valid, 5'b00000);
    chk("rst_en", bus.en_stage, 5'b11111);
    chk("rst_stall", bus.stall_cnt, 16'd0);
    chk("rst_flush", bus.flush_cnt, 16'd0);
    chk("rst_terr", bus.timeout_err, 1'b0);
    chk("rst_abort", bus.mem_abort, 1'b0);

    reset        = 1'b1;
    bus.if_valid = 1'b1;
    sif.if_valid = 1'b1;
    sif.dmem_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("fill_valid", bus.valid, 5'b00111);

    // Load-use on rs
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd3;
    bus.id_rs       = 5'd3;
    bus.id_use_rs   = 1'b1;
    #1 chk("lu_rs_en", bus.en_stage, 5'b11100);
    @(negedge clk);
    chk("lu_rs_valid", bus.valid, 5'b01011);
    chk("lu_rs_stall", bus.stall_cnt, 16'd1);
    #1 chk("lu_one_cycle_en", bus.en_stage, 5'b11111);
    @(negedge clk);
    chk("lu_after_valid", bus.valid, 5'b10111);

    // Destination r0 never stalls
    bus.ex_rd = 5'd0;
    bus.id_rs = 5'd0;
    #1 chk("lu_r0_en", bus.en_stage, 5'b11111);
    @(negedge clk);
    chk("lu_r0_valid", bus.valid, 5'b01111);

    // Load-use on rt
    bus.ex_rd     = 5'd5;
    bus.id_rt     = 5'd5;
    bus.id_use_rt = 1'b1;
    bus.id_use_rs = 1'b0;
    #1 chk("lu_rt_en", bus.en_stage, 5'b11100);
    @(negedge clk);
    chk("lu_rt_valid", bus.valid, 5'b11011);
    chk("lu_rt_stall", bus.stall_cnt, 16'd2);
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_use_rt   = 1'b0;

    // Taken branch with a simultaneous load-use
    repeat (2) @(negedge clk);
    chk("br_pre_valid", bus.valid, 5'b01111);
    bus.br_taken    = 1'b1;
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd7;
    bus.id_rs       = 5'd7;
    bus.id_use_rs   = 1'b1;
    #1 chk("br_en", bus.en_stage, 5'b11111);
    @(negedge clk);
    chk("br_valid", bus.valid, 5'b10001);
    chk("br_flush_cnt", bus.flush_cnt, 16'd1);
    chk("br_stall", bus.stall_cnt, 16'd2);
    bus.ex_mem_read = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.id_rs       = 5'd0;
    bus.id_use_rs   = 1'b0;
    // Branch signal with MEM empty is ignored
    @(negedge clk);
    chk("br_novalid_valid", bus.valid, 5'b00011);
    chk("br_novalid_cnt", bus.flush_cnt, 16'd1);
    bus.br_taken = 1'b0;

    // Memory wait of three cycles
    repeat (2) @(negedge clk);
    chk("mw_pre_valid", bus.valid, 5'b01111);
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_en", bus.en_stage, 5'b10000);
      @(negedge clk);
      chk("mw_valid", bus.valid, 5'b01111);
    end
    chk("mw_stall", bus.stall_cnt, 16'd5);
    bus.dmem_ready = 1'b1;
    #1 chk("mw_ready_en", bus.en_stage, 5'b11111);
    chk("mw_ready_abort", bus.mem_abort, 1'b0);
    @(negedge clk);
    chk("mw_done_valid", bus.valid, 5'b11111);
    chk("mw_done_stall", bus.stall_cnt, 16'd5);

    // Flush arriving during a memory wait is deferred
    bus.dmem_ready = 1'b0;
    bus.flush      = 1'b1;
    #1 chk("fl_wait_en", bus.en_stage, 5'b10000);
    @(negedge clk);
    chk("fl_wait_valid", bus.valid, 5'b01111);
    chk("fl_wait_cnt", bus.flush_cnt, 16'd1);
    bus.flush = 1'b0;
    #1 chk("fl_wait2_en", bus.en_stage, 5'b10000);
    @(negedge clk);
    chk("fl_wait2_cnt", bus.flush_cnt, 16'd1);
    chk("fl_wait2_stall", bus.stall_cnt, 16'd7);
    bus.dmem_ready = 1'b1;
    #1 chk("fl_apply_en", bus.en_stage, 5'b11111);
    @(negedge clk);
    chk("fl_apply_valid", bus.valid, 5'b10000);
    chk("fl_apply_cnt", bus.flush_cnt, 16'd2);
    bus.dmem_req   = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.if_valid   = 1'b0;
    @(negedge clk);
    chk("fl_once_valid", bus.valid, 5'b00000);
    chk("fl_once_cnt", bus.flush_cnt, 16'd2);

    // Memory never ready: 15 wait cycles then abort
    bus.if_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("to_pre_valid", bus.valid, 5'b01111);
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1 chk("to_wait_en", bus.en_stage, 5'b10000);
      chk("to_wait_abort", bus.mem_abort, 1'b0);
      @(negedge clk);
    end
    #1 chk("to_abort", bus.mem_abort, 1'b1);
    chk("to_abort_en", bus.en_stage, 5'b11111);
    @(negedge clk);
    chk("to_terr", bus.timeout_err, 1'b1);
    chk("to_valid", bus.valid, 5'b01111);
    chk("to_stall", bus.stall_cnt, 16'd22);
    #1 chk("to_rewait_abort", bus.mem_abort, 1'b0);
    chk("to_rewait_en", bus.en_stage, 5'b10000);
    bus.dmem_req = 1'b0;
    @(negedge clk);
    chk("to_terr_sticky", bus.timeout_err, 1'b1);
    chk("to_post_valid", bus.valid, 5'b11111);

    // 4-bit counters saturate after many stalls
    chk("sat_stall", sif.stall_cnt, 4'hF);
    chk("sat_terr", sif.timeout_err, 1'b1);
    chk("sat_flush", sif.flush_cnt, 4'h0);

    // Reset in the middle of a wait with a flush pending
    bus.dmem_req = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk("mr_pre_stall", bus.stall_cnt, 16'd23);
    #2 reset = 1'b0;
    #1 chk("mr_valid", bus.valid, 5'b00000);
    chk("mr_en", bus.en_stage, 5'b11111);
    chk("mr_stall", bus.stall_cnt, 16'd0);
    chk("mr_flush", bus.flush_cnt, 16'd0);
    chk("mr_terr", bus.timeout_err, 1'b0);
    chk("mr_abort", bus.mem_abort, 1'b0);
    chk("mr_sat_stall", sif.stall_cnt, 4'h0);
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.dmem_req = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    chk("mr_drop_valid", bus.valid, 5'b00001);
    chk("mr_drop_flush", bus.flush_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
